// File: rtl/qed_pkg.sv
// Shared types and constants for the QED commit-consistency monitor.
package qed_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2
    } qed_mon_state_t;

    localparam int ERR_DUP_AHEAD   = 0;
    localparam int ERR_SKEW_OVER   = 1;
    localparam int ERR_INIT_COMMIT = 2;

endpackage

// File: rtl/qed_lane_popcount.sv
// Combinational count of set bits across the commit lanes.
module qed_lane_popcount #(
    parameter int NUM_LANES = 1,
    parameter int CW        = $clog2(NUM_LANES + 1)
) (
    input  logic [NUM_LANES-1:0] bits,
    output logic [CW-1:0]        count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            count = count + CW'(bits[i]);
        end
    end

endmodule

// File: rtl/qed_sync_monitor.sv
// Tracks original/duplicate commit streams after a clean init phase and flags QED consistency.
// commit_valid is a one-way strobe: there is no ready, every set lane is sampled on its edge.
module qed_sync_monitor
    import qed_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int NUM_LANES   = 1,
    parameter int INIT_CYCLES = 4,
    parameter int MAX_SKEW    = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_LANES-1:0] commit_valid,
    input  logic [NUM_LANES-1:0] commit_is_dup,
    input  logic                 flush,
    output logic                 init_hold,
    output logic [CNT_W-1:0]     num_orig,
    output logic [CNT_W-1:0]     num_dup,
    output logic                 qed_ready,
    output logic                 sat,
    output logic [2:0]           err,
    output logic [1:0]           dbg_state
);

    localparam int PW = $clog2(NUM_LANES + 1);
    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [63:0]   SKEW_LIM  = 64'(MAX_SKEW);

    qed_mon_state_t   state_q, state_d;
    logic [IW-1:0]    init_q, init_d;
    logic [CNT_W-1:0] orig_q, orig_d, dup_q, dup_d;
    logic             sat_q, sat_d;
    logic [2:0]       err_q, err_d;

    logic [NUM_LANES-1:0] orig_mask, dup_mask;
    logic [PW-1:0]        pc_orig, pc_dup;
    logic [CNT_W:0]       sum_orig, sum_dup;
    logic [CNT_W-1:0]     new_orig, new_dup, skew;

    assign orig_mask = commit_valid & ~commit_is_dup;
    assign dup_mask  = commit_valid & commit_is_dup;

    qed_lane_popcount #(.NUM_LANES(NUM_LANES), .CW(PW)) u_pc_orig (
        .bits  (orig_mask),
        .count (pc_orig)
    );

    qed_lane_popcount #(.NUM_LANES(NUM_LANES), .CW(PW)) u_pc_dup (
        .bits  (dup_mask),
        .count (pc_dup)
    );

    // Carry out of the widened sum means the counter would wrap; clamp instead.
    always_comb begin
        sum_orig = {1'b0, orig_q} + (CNT_W + 1)'(pc_orig);
        sum_dup  = {1'b0, dup_q} + (CNT_W + 1)'(pc_dup);
        new_orig = sum_orig[CNT_W] ? '1 : sum_orig[CNT_W-1:0];
        new_dup  = sum_dup[CNT_W] ? '1 : sum_dup[CNT_W-1:0];
        skew     = new_orig - new_dup;
    end

    always_comb begin
        state_d = state_q;
        init_d  = init_q;
        orig_d  = orig_q;
        dup_d   = dup_q;
        sat_d   = sat_q;
        err_d   = err_q;
        if (flush) begin
            state_d = INIT;
            init_d  = '0;
            orig_d  = '0;
            dup_d   = '0;
            sat_d   = 1'b0;
            err_d   = '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (|commit_valid) begin
                        err_d[ERR_INIT_COMMIT] = 1'b1;
                        state_d                = ERROR;
                    end else if (init_q == INIT_LAST) begin
                        state_d = RUN;
                    end else begin
                        init_d = init_q + IW'(1);
                    end
                end
                RUN: begin
                    orig_d = new_orig;
                    dup_d  = new_dup;
                    if (sum_orig[CNT_W] || sum_dup[CNT_W]) sat_d = 1'b1;
                    // Checks use the post-update values so a same-cycle orig/dup pair is legal.
                    if (new_dup > new_orig) begin
                        err_d[ERR_DUP_AHEAD] = 1'b1;
                        state_d              = ERROR;
                    end else if (64'(skew) > SKEW_LIM) begin
                        err_d[ERR_SKEW_OVER] = 1'b1;
                        state_d              = ERROR;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= INIT;
            init_q  <= '0;
            orig_q  <= '0;
            dup_q   <= '0;
            sat_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= init_d;
            orig_q  <= orig_d;
            dup_q   <= dup_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    assign init_hold = (state_q == INIT);
    assign num_orig  = orig_q;
    assign num_dup   = dup_q;
    assign sat       = sat_q;
    assign err       = err_q;
    assign dbg_state = state_q;
    assign qed_ready = (state_q == RUN) && (orig_q == dup_q) && (orig_q != '0) && !sat_q;

endmodule

// File: tb/tb_qed_sync_monitor.sv
// Directed plus random bench for qed_sync_monitor: two instances differing only in MAX_SKEW.
module tb_qed_sync_monitor;
    import qed_pkg::*;

    localparam int CNT_W  = 4;
    localparam int NL     = 2;
    localparam int IC     = 4;
    localparam int SKEW_A = 32;
    localparam int SKEW_B = 2;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int P_INIT = 0;
    localparam int P_RUN  = 1;
    localparam int P_ERR  = 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          flush;
    logic [NL-1:0] commit_valid, commit_is_dup;

    logic             a_init_hold, b_init_hold, a_qed_ready, b_qed_ready, a_sat, b_sat;
    logic [CNT_W-1:0] a_num_orig, a_num_dup, b_num_orig, b_num_dup;
    logic [2:0]       a_err, b_err;
    logic [1:0]       a_dbg_state, b_dbg_state;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain integer counts per instance.
    int       m_phase[2];
    int       m_icnt[2];
    int       m_no[2];
    int       m_nd[2];
    bit       m_sat[2];
    bit [2:0] m_err[2];
    int       m_skew[2] = '{SKEW_A, SKEW_B};

    qed_sync_monitor #(.CNT_W(CNT_W), .NUM_LANES(NL), .INIT_CYCLES(IC), .MAX_SKEW(SKEW_A)) dut_a (
        .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
        .flush(flush), .init_hold(a_init_hold), .num_orig(a_num_orig), .num_dup(a_num_dup),
        .qed_ready(a_qed_ready), .sat(a_sat), .err(a_err), .dbg_state(a_dbg_state)
    );

    qed_sync_monitor #(.CNT_W(CNT_W), .NUM_LANES(NL), .INIT_CYCLES(IC), .MAX_SKEW(SKEW_B)) dut_b (
        .clk(clk), .resetn(resetn), .commit_valid(commit_valid), .commit_is_dup(commit_is_dup),
        .flush(flush), .init_hold(b_init_hold), .num_orig(b_num_orig), .num_dup(b_num_dup),
        .qed_ready(b_qed_ready), .sat(b_sat), .err(b_err), .dbg_state(b_dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int ones(input logic [NL-1:0] x);
        int c = 0;
        for (int i = 0; i < NL; i++) c += int'(x[i]);
        return c;
    endfunction

    function automatic qed_mon_state_t st_of(input int p);
        return (p == P_INIT) ? INIT : (p == P_RUN) ? RUN : ERROR;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = P_INIT;
            m_icnt[k]  = 0;
            m_no[k]    = 0;
            m_nd[k]    = 0;
            m_sat[k]   = 1'b0;
            m_err[k]   = 3'b000;
        end
    endtask

    task automatic model_step(input logic [NL-1:0] v, input logic [NL-1:0] d, input logic f);
        int o, dd;
        if (f) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (m_phase[k] == P_INIT) begin
                if (v != '0) begin
                    m_err[k][2] = 1'b1;
                    m_phase[k]  = P_ERR;
                end else begin
                    m_icnt[k]++;
                    if (m_icnt[k] == IC) m_phase[k] = P_RUN;
                end
            end else if (m_phase[k] == P_RUN) begin
                o  = m_no[k] + ones(v & ~d);
                dd = m_nd[k] + ones(v & d);
                if (o > CMAX) begin o = CMAX; m_sat[k] = 1'b1; end
                if (dd > CMAX) begin dd = CMAX; m_sat[k] = 1'b1; end
                m_no[k] = o;
                m_nd[k] = dd;
                if (dd > o) begin
                    m_err[k][0] = 1'b1;
                    m_phase[k]  = P_ERR;
                end else if (o - dd > m_skew[k]) begin
                    m_err[k][1] = 1'b1;
                    m_phase[k]  = P_ERR;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    endtask

    task automatic check_inst(input int k, input string p, input logic ih,
                              input logic [CNT_W-1:0] no, input logic [CNT_W-1:0] nd,
                              input logic rdy, input logic s, input logic [2:0] e,
                              input logic [1:0] st);
        bit exp_rdy;
        exp_rdy = (m_phase[k] == P_RUN) && (m_no[k] == m_nd[k]) && (m_no[k] != 0) && !m_sat[k];
        check({p, "_init_hold"}, 32'(ih), 32'(m_phase[k] == P_INIT));
        check({p, "_num_orig"}, 32'(no), 32'(m_no[k]));
        check({p, "_num_dup"}, 32'(nd), 32'(m_nd[k]));
        check({p, "_qed_ready"}, 32'(rdy), 32'(exp_rdy));
        check({p, "_sat"}, 32'(s), 32'(m_sat[k]));
        check({p, "_err"}, 32'(e), 32'(m_err[k]));
        check({p, "_state"}, 32'(st), 32'(st_of(m_phase[k])));
    endtask

    task automatic check_all();
        check_inst(0, "a", a_init_hold, a_num_orig, a_num_dup, a_qed_ready, a_sat, a_err, a_dbg_state);
        check_inst(1, "b", b_init_hold, b_num_orig, b_num_dup, b_qed_ready, b_sat, b_err, b_dbg_state);
    endtask

    task automatic cyc(input logic [NL-1:0] v, input logic [NL-1:0] d, input logic f);
        commit_valid  = v;
        commit_is_dup = d;
        flush         = f;
        @(posedge clk);
        model_step(v, d, f);
        #1;
        check_all();
    endtask

    initial begin
        logic [NL-1:0] rv, rd;
        logic          rf;

        resetn        = 1'b1;
        flush         = 1'b0;
        commit_valid  = '0;
        commit_is_dup = '0;
        model_clear();
        #1 resetn = 1'b0;
        #1;
        check_all();
        check("reset_init_hold", 32'(a_init_hold), 32'd1);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Init phase: init_hold stays up for exactly IC edges.
        for (int i = 0; i < IC; i++) begin
            cyc('0, '0, 1'b0);
            check("init_hold_edge", 32'(a_init_hold), 32'(i < IC - 1));
        end

        // Three originals then three duplicates on lane 0.
        repeat (3) cyc(2'b01, 2'b00, 1'b0);
        check("b_err_skew", 32'(b_err), 32'b010);
        repeat (3) cyc(2'b01, 2'b01, 1'b0);
        check("a_orig_3", 32'(a_num_orig), 32'd3);
        check("a_dup_3", 32'(a_num_dup), 32'd3);
        check("a_ready_3", 32'(a_qed_ready), 32'd1);

        // Same-cycle orig+dup pair across two lanes.
        cyc('0, '0, 1'b1);
        check("flush_init_hold", 32'(a_init_hold), 32'd1);
        check("flush_orig", 32'(a_num_orig), 32'd0);
        repeat (IC) cyc('0, '0, 1'b0);
        cyc(2'b11, 2'b01, 1'b0);
        check("pair_ready", 32'(a_qed_ready), 32'd1);
        check("pair_err", 32'(b_err), 32'd0);

        // Duplicate ahead of originals.
        cyc('0, '0, 1'b1);
        repeat (IC) cyc('0, '0, 1'b0);
        cyc(2'b01, 2'b01, 1'b0);
        check("dup_ahead_err", 32'(a_err), 32'b001);
        check("dup_ahead_state", 32'(a_dbg_state), 32'(ERROR));
        repeat (2) cyc(2'b11, 2'b00, 1'b0);
        check("error_frozen_orig", 32'(a_num_orig), 32'd0);

        // Commit during init, then flush restarts a full init window.
        cyc('0, '0, 1'b1);
        cyc(2'b01, 2'b00, 1'b0);
        check("init_commit_err", 32'(a_err), 32'b100);
        repeat (2) cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b1);
        check("reflush_err", 32'(a_err), 32'd0);
        for (int i = 0; i < IC; i++) begin
            cyc('0, '0, 1'b0);
            check("reinit_hold", 32'(a_init_hold), 32'(i < IC - 1));
        end

        // Saturation with paired commits.
        repeat (17) cyc(2'b11, 2'b10, 1'b0);
        check("sat_orig", 32'(a_num_orig), 32'd15);
        check("sat_dup", 32'(a_num_dup), 32'd15);
        check("sat_flag", 32'(a_sat), 32'd1);
        check("sat_ready", 32'(a_qed_ready), 32'd0);

        // Flush wins over an erroring commit in the same cycle.
        cyc('0, '0, 1'b1);
        repeat (IC) cyc('0, '0, 1'b0);
        cyc(2'b11, 2'b10, 1'b0);
        cyc(2'b01, 2'b01, 1'b1);
        check("flush_prio_err", 32'(a_err), 32'd0);
        check("flush_prio_hold", 32'(a_init_hold), 32'd1);

        // Asynchronous reset mid-cycle.
        repeat (IC) cyc('0, '0, 1'b0);
        repeat (2) cyc(2'b11, 2'b10, 1'b0);
        #2 resetn = 1'b0;
        model_clear();
        #1;
        check_all();
        check("async_orig", 32'(a_num_orig), 32'd0);
        #2 resetn = 1'b1;

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            rf = ($urandom_range(0, 15) == 0);
            rv = ($urandom_range(0, 2) == 0) ? '0 : NL'($urandom_range(0, 3));
            rd = NL'($urandom & $urandom);
            cyc(rv, rd, rf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qed_sync_monitor.md
# qed_sync_monitor

Parametrised QED commit-consistency monitor for the picorv32 QED demo. It replaces the fixed clean-start constraint on the QED counters with an active block. After reset or flush it holds the design in a clean initial phase, then counts original and duplicate instruction commits across N commit lanes. It flags the QED-consistent point (orig count == dup count, nonzero) and latches sticky errors when the two streams diverge illegally. It sits beside `dut`, is driven by the commit stage, and its outputs feed the formal property harness.

## Interface
- `CNT_W`, 16: width of each commit counter.
- `NUM_LANES`, 1: commit ports observed per cycle (1..8).
- `INIT_CYCLES`, 4: cycles of `init_hold` after reset or flush (>=1).
- `MAX_SKEW`, 32: maximum legal `num_orig - num_dup`.

Ports:
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low.
- `commit_valid`  in  NUM_LANES  per-lane instruction commit.
- `commit_is_dup`  in  NUM_LANES  per-lane: 1 = duplicate stream, 0 = original; ignored where valid=0.
- `flush`  in  1  synchronous clear and restart of init phase.
- `init_hold`  out  1  high during INIT; the harness uses it to constrain the design clean.
- `num_orig`  out  CNT_W  committed originals.
- `num_dup`  out  CNT_W  committed duplicates.
- `qed_ready`  out  1  consistent point reached.
- `sat`  out  1  sticky: a counter saturated.
- `err`  out  3  sticky cause: [0] dup_ahead, [1] skew_over, [2] commit_in_init.

## Operation
- States: INIT, RUN, ERROR.
- Reset: state=INIT, init counter=0, counters=0, `sat`=0, `err`=0, `init_hold`=1, `qed_ready`=0.
- **INIT**
  - `init_hold`=1.
  - Counts INIT_CYCLES clocks, then moves to RUN.
  - Any commit_valid bit set: `err[2]` is set, state moves to ERROR, and the commit is not counted.
- **RUN**
  - Each cycle, add no = popcount(valid & ~is_dup) and nd = popcount(valid & is_dup).
  - Checks use post-update values, so an orig and a dup committing in the same cycle is legal.
  - new_dup > new_orig: set `err[0]`, go to ERROR.
  - new_orig - new_dup > MAX_SKEW: set `err[1]`, go to ERROR.
  - Counters update in the erroring cycle as well.
- **ERROR**
  - Counters freeze and commits are ignored.
  - State is held until flush or reset.
- **Saturation**
  - Each counter clamps at 2^CNT_W-1.
  - Any clamp sets `sat`, which is sticky.
  - Skew checks continue on the clamped values.
- **Flush**
  - From any state: counters=0, `sat`=0, `err`=0, init counter=0, state=INIT.
  - Flush has priority over commits and error detection in the same cycle.
- **qed_ready** = (state==RUN) & (num_orig==num_dup) & (num_orig!=0) & ~`sat`. It is decoded from registers only.

## Timing
- Counter, state and flag outputs are registered, with 1-cycle latency from a commit to the updated `num_*`.
- `qed_ready` and `err` are visible the cycle after the triggering commit edge.
- After `resetn` deasserts, `init_hold` stays high for exactly INIT_CYCLES rising edges. Commits are first counted at edge INIT_CYCLES+1.
- Flush is seen at edge t. From t+1: `init_hold`=1 and all counters are 0.
- Asynchronous reset mid-operation clears everything immediately, with no dependence on the clock.
- Combinational path from inputs to outputs: none.

## Structure
- Package `qed_pkg`:
  - state enum `qed_mon_state_t` {INIT, RUN, ERROR};
  - err bit index constants `ERR_DUP_AHEAD`=0, `ERR_SKEW_OVER`=1, `ERR_INIT_COMMIT`=2.
- Sub-module `qed_lane_popcount`: parametrised NUM_LANES, a combinational count of masked valid bits. Instantiate it twice, once for originals and once for duplicates.
- Saturating add is implemented inline: use a CNT_W+1-bit sum, clamping on the carry.

## Test plan
- Reset, idle 4 cycles, then 3 orig then 3 dup commits (NUM_LANES=1) -> `init_hold` falls after edge 4; `num_orig`=3, `num_dup`=3; `qed_ready`=1 the cycle after the last dup.
- NUM_LANES=2, one cycle of valid=11, is_dup=01 in RUN -> `num_orig`=1, `num_dup`=1, `qed_ready`=1, `err`=0.
- Dup commit with `num_orig`=0 in RUN -> `err`=3'b001, state ERROR, `qed_ready`=0; later commits leave counters unchanged.
- MAX_SKEW=2, 3 orig commits with no dup -> `err[1]`=1 after the third commit.
- Commit during INIT -> `err[2]`=1, counters stay 0; flush -> `err`=0, `init_hold`=1 for 4 cycles.
- CNT_W=4, 17 orig and 17 dup paired commits -> both counters stay at 15, `sat`=1, `qed_ready`=0.
